// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Multi-cycle MUL/DIV sequencer beside the EX-stage ALU.
//                Radix-2 shift-add multiply and restoring divide, sharing
//                one WIDTH-bit adder. The result lands in the HI/LO pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cancel,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [1:0]           r_op;
   logic                 r_sa;
   logic                 r_sb;
   // r_acc: product high half / partial remainder
   // r_q  : multiplier (shifted out) / dividend shifting into quotient
   // r_b  : multiplicand / divisor
   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     r_q;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_dbz;

   logic                 w_accept;
   logic                 w_sa;
   logic                 w_sb;
   logic                 w_div0;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH-1:0]     w_add_a;
   logic [WIDTH-1:0]     w_add_b;
   logic                 w_add_cin;
   logic [WIDTH:0]       w_add_sum;
   logic [WIDTH-1:0]     w_shift;
   logic                 w_div_ok;
   logic [WIDTH-1:0]     w_fix_hi;
   logic [WIDTH-1:0]     w_fix_lo;

   // Operand conditioning at accept: magnitudes and signs (signed ops only)
   assign w_accept = (r_state == S_IDLE) & start & ~cancel;
   assign w_sa     = op[0] & opa[WIDTH-1];
   assign w_sb     = op[0] & opb[WIDTH-1];
   assign w_abs_a  = w_sa ? -opa : opa;
   assign w_abs_b  = w_sb ? -opb : opb;
   assign w_div0   = op[1] & (opb == '0);

   // Divide step: shift the next dividend bit into the partial remainder.
   // The trial subtract succeeds if the shifted-out MSB was set or no borrow.
   assign w_shift  = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
   assign w_div_ok = r_acc[WIDTH-1] | w_add_sum[WIDTH];

   // Shared adder operand select: add multiplicand (MUL) or subtract divisor (DIV)
   always_comb begin
      w_add_a   = r_acc;
      w_add_b   = '0;
      w_add_cin = 1'b0;
      if (r_op[1]) begin
         w_add_a   = w_shift;
         w_add_b   = ~r_b;
         w_add_cin = 1'b1;
      end else if (r_q[0]) begin
         w_add_b   = r_b;
      end
   end

   assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};

   // Sign correction applied in FIX
   always_comb begin
      w_fix_hi = r_acc;
      w_fix_lo = r_q;
      if (r_op[1]) begin
         if (r_op[0] & (r_sa ^ r_sb)) w_fix_lo = -r_q;
         if (r_op[0] & r_sa)          w_fix_hi = -r_acc;
      end else if (r_op[0] & (r_sa ^ r_sb)) begin
         {w_fix_hi, w_fix_lo} = -{r_acc, r_q};
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state and status outputs
   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      busy         = (r_state != S_IDLE);
      done         = (r_state == S_DONE);
      unique case (r_state)
         S_IDLE: begin
            stall = w_accept & rst;
            if (w_accept) w_next_state = w_div0 ? S_DONE : S_CALC;
         end
         S_CALC: begin
            stall = 1'b1;
            if (cancel)                   w_next_state = S_IDLE;
            else if (r_cnt == c_cnt_last) w_next_state = S_FIX;
         end
         S_FIX: begin
            stall        = 1'b1;
            w_next_state = cancel ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Datapath: operand latch, iteration steps and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_sa  <= 1'b0;
         r_sb  <= 1'b0;
         r_acc <= '0;
         r_q   <= '0;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_dbz <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  r_op  <= op;
                  r_sa  <= w_sa;
                  r_sb  <= w_sb;
                  r_acc <= '0;
                  r_q   <= op[1] ? w_abs_a : w_abs_b;
                  r_b   <= op[1] ? w_abs_b : w_abs_a;
                  r_dbz <= w_div0;
                  if (w_div0) begin
                     r_hi <= opa;
                     r_lo <= '1;
                  end
               end
            end
            S_CALC: begin
               if (!cancel) begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
                  if (r_op[1]) begin
                     r_acc <= w_div_ok ? w_add_sum[WIDTH-1:0] : w_shift;
                     r_q   <= {r_q[WIDTH-2:0], w_div_ok};
                  end else begin
                     r_acc <= w_add_sum[WIDTH:1];
                     r_q   <= {w_add_sum[0], r_q[WIDTH-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!cancel) begin
                  r_hi <= w_fix_hi;
                  r_lo <= w_fix_lo;
               end
            end
            S_DONE: begin
            end
         endcase
      end
   end

   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Self-checking bench for alu_muldiv_seq with a result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         cancel = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         stall, busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_muldiv_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .opa         (opa),
      .opb         (opb),
      .cancel      (cancel),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   // Reference arithmetic for every op
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t                 e;
      logic [2*W-1:0]       p;
      logic signed [2*W-1:0] xa, xb;
      logic signed [W-1:0]  sa, sb;
      e = '0;
      sa = a;
      sb = b;
      case (o)
         2'b00: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.hi = p[2*W-1:W]; e.lo = p[W-1:0];
         end
         2'b01: begin
            xa = {{W{a[W-1]}}, a};
            xb = {{W{b[W-1]}}, b};
            p = xa * xb;
            e.hi = p[2*W-1:W]; e.lo = p[W-1:0];
         end
         default: begin
            if (b == '0) begin
               e.hi = a; e.lo = '1; e.dbz = 1'b1;
            end else if (o == 2'b10) begin
               e.lo = a / b; e.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = '0;
            end else begin
               e.lo = sa / sb; e.hi = sa % sb;
            end
         end
      endcase
      return e;
   endfunction

   // Issue one op, push its expectation, wait (bounded) for done
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int stall_hi, output logic stall_at_done,
                         output logic timed_out);
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = b;
      sb_q.push_back(model(o, a, b));
      #1;
      lat = -1; timed_out = 1'b1; stall_at_done = 1'b1;
      stall_hi = stall ? 1 : 0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= W + 8; k++) begin
         #1;
         if (done) begin
            lat = k; stall_at_done = stall; timed_out = 1'b0;
            break;
         end
         if (stall) stall_hi++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0)
         begin errors++; $display("FAIL reset_status: busy=%b done=%b stall=%b required 0 0 0", busy, done, stall); end
      checks++;
      if (hi !== '0 || lo !== '0 || div_by_zero !== 1'b0)
         begin errors++; $display("FAIL reset_result: hi=%h lo=%h dbz=%b required 0 0 0", hi, lo, div_by_zero); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_mul();
      logic [1:0]   ops [3];
      logic [W-1:0] as  [3];
      logic [W-1:0] bs  [3];
      int lat, sh; logic sd, to; exp_t e;
      ops[0] = 2'b00; as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF;
      ops[1] = 2'b01; as[1] = 32'hFFFF_FFFD; bs[1] = 32'd5;
      ops[2] = 2'b01; as[2] = 32'h8000_0000; bs[2] = 32'h8000_0000;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], bs[i], lat, sh, sd, to);
         e = sb_q.pop_front();
         checks++;
         if (to || lat != W + 2)
            begin errors++; $display("FAIL mul%0d_latency: got %0d required %0d (timeout=%b)", i, lat, W + 2, to); end
         checks++;
         if (hi !== e.hi || lo !== e.lo || div_by_zero !== 1'b0)
            begin errors++; $display("FAIL mul%0d_result: hi=%h lo=%h dbz=%b required %h %h 0", i, hi, lo, div_by_zero, e.hi, e.lo); end
         checks++;
         if (sh != W + 2 || sd !== 1'b0)
            begin errors++; $display("FAIL mul%0d_stall: high %0d cycles, at done %b; required %0d, 0", i, sh, sd, W + 2); end
         @(negedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL mul%0d_single_done: done=%b busy=%b required 0 0", i, done, busy); end
      end
   endtask

   task automatic test_div();
      logic [1:0]   ops [3];
      logic [W-1:0] as  [3];
      logic [W-1:0] bs  [3];
      int lat, sh; logic sd, to; exp_t e;
      ops[0] = 2'b11; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;
      ops[1] = 2'b10; as[1] = 32'd100;       bs[1] = 32'd7;
      ops[2] = 2'b11; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], bs[i], lat, sh, sd, to);
         e = sb_q.pop_front();
         checks++;
         if (to || lat != W + 2)
            begin errors++; $display("FAIL div%0d_latency: got %0d required %0d (timeout=%b)", i, lat, W + 2, to); end
         checks++;
         if (hi !== e.hi || lo !== e.lo || div_by_zero !== 1'b0)
            begin errors++; $display("FAIL div%0d_result: hi=%h lo=%h dbz=%b required %h %h 0", i, hi, lo, div_by_zero, e.hi, e.lo); end
      end
   endtask

   task automatic test_div_by_zero();
      int lat, sh; logic sd, to; exp_t e;
      run_op(2'b10, 32'd5, 32'd0, lat, sh, sd, to);
      e = sb_q.pop_front();
      checks++;
      if (to || lat != 1)
         begin errors++; $display("FAIL div0_latency: got %0d required 1 (timeout=%b)", lat, to); end
      checks++;
      if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz)
         begin errors++; $display("FAIL div0_result: hi=%h lo=%h dbz=%b required %h %h %b", hi, lo, div_by_zero, e.hi, e.lo, e.dbz); end
      run_op(2'b00, 32'd6, 32'd7, lat, sh, sd, to);
      e = sb_q.pop_front();
      checks++;
      if (to || hi !== e.hi || lo !== e.lo || div_by_zero !== 1'b0)
         begin errors++; $display("FAIL div0_clear: hi=%h lo=%h dbz=%b required %h %h 0", hi, lo, div_by_zero, e.hi, e.lo); end
   endtask

   task automatic test_cancel();
      logic [W-1:0] h0, l0; int seen;
      h0 = hi; l0 = lo;
      // cancel with start in IDLE: nothing accepted
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd3;
      #1;
      checks++;
      if (stall !== 1'b0)
         begin errors++; $display("FAIL cancel_idle_stall: got %b required 0", stall); end
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0)
         begin errors++; $display("FAIL cancel_idle_busy: got %b required 0", busy); end
      // cancel in CALC on cycle 10
      @(negedge clk);
      start = 1'b1; op = 2'b00; opa = 32'd1234; opb = 32'd5678;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0)
         begin errors++; $display("FAIL cancel_calc_idle: busy=%b stall=%b required 0 0", busy, stall); end
      seen = 0;
      for (int k = 0; k < W + 8; k++) begin
         @(negedge clk); #1;
         if (done) seen++;
      end
      checks++;
      if (seen != 0 || hi !== h0 || lo !== l0)
         begin errors++; $display("FAIL cancel_no_result: done seen %0d hi=%h lo=%h required 0 %h %h", seen, hi, lo, h0, l0); end
   endtask

   task automatic test_start_while_busy();
      int lat, extra; exp_t e;
      @(negedge clk);
      start = 1'b1; op = 2'b10; opa = 32'd1000; opb = 32'd33;
      sb_q.push_back(model(2'b10, 32'd1000, 32'd33));
      @(negedge clk);
      start = 1'b0;
      lat = -1; extra = 0;
      for (int k = 1; k <= 2 * W + 20; k++) begin
         if (k == 5) begin start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9; end
         if (k == 6) start = 1'b0;
         #1;
         if (done) begin
            if (lat < 0) begin
               lat = k;
               e = sb_q.pop_front();
               checks++;
               if (hi !== e.hi || lo !== e.lo)
                  begin errors++; $display("FAIL busy_start_result: hi=%h lo=%h required %h %h", hi, lo, e.hi, e.lo); end
            end else extra++;
         end
         @(negedge clk);
      end
      checks++;
      if (lat != W + 2 || extra != 0)
         begin errors++; $display("FAIL busy_start_ignored: done at %0d extra %0d required %0d 0", lat, extra, W + 2); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      start = 1'b1; op = 2'b00; opa = 32'd7; opb = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2;
      rst = 1'b0; start = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL async_rst_status: busy=%b stall=%b done=%b required 0 0 0", busy, stall, done); end
      checks++;
      if (hi !== '0 || lo !== '0 || div_by_zero !== 1'b0)
         begin errors++; $display("FAIL async_rst_result: hi=%h lo=%h dbz=%b required 0 0 0", hi, lo, div_by_zero); end
      @(negedge clk);
      start = 1'b0; rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      int n_done; exp_t e;
      @(negedge clk);
      start = 1'b1; op = 2'b10; opa = 32'd100; opb = 32'd7;
      sb_q.push_back(model(2'b10, 32'd100, 32'd7));
      @(negedge clk);
      op = 2'b01; opa = 32'hFFFF_FFFD; opb = 32'd5;
      sb_q.push_back(model(2'b01, 32'hFFFF_FFFD, 32'd5));
      n_done = 0;
      for (int k = 1; k <= 3 * W + 20; k++) begin
         if (k == W + 4) start = 1'b0;
         #1;
         if (done) begin
            n_done++;
            checks++;
            if (k != (n_done == 1 ? W + 2 : 2 * W + 5) || stall !== 1'b0)
               begin errors++; $display("FAIL b2b_done%0d_timing: cycle %0d stall=%b required %0d 0", n_done, k, stall, (n_done == 1 ? W + 2 : 2 * W + 5)); end
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               checks++;
               if (hi !== e.hi || lo !== e.lo)
                  begin errors++; $display("FAIL b2b_done%0d_result: hi=%h lo=%h required %h %h", n_done, hi, lo, e.hi, e.lo); end
            end
         end
         @(negedge clk);
      end
      checks++;
      if (n_done != 2 || sb_q.size() != 0)
         begin errors++; $display("FAIL b2b_count: done pulses %0d pending %0d required 2 0", n_done, sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_by_zero();
      test_cancel();
      test_start_while_busy();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
